// File: rtl/param_alu.sv
// Multi-cycle ALU: add/and/xor in one EXEC cycle, unsigned multiply over MUL_CYCLES cycles.
// Optional illegal-opcode flag port err is built when ALU_ERR_FLAG_EN is defined.
module param_alu #(
    parameter int WIDTH      = 8,
    parameter int MUL_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           op,
    input  logic                 start,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
`ifdef ALU_ERR_FLAG_EN
    ,
    output logic                 err
`endif
);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_RST = 3'b111;

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    // Counter runs from MUL_CYCLES-1 down to 0, so the product lands MUL_CYCLES edges after acceptance
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE,
        WAIT_LOW
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2:0]           op_q, op_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
`ifdef ALU_ERR_FLAG_EN
    logic                 err_q, err_d;
`endif

    function automatic logic [2*WIDTH-1:0] alu_compute(input logic [2:0] o,
                                                       input logic [WIDTH-1:0] x,
                                                       input logic [WIDTH-1:0] y);
        logic [2*WIDTH-1:0] r;
        r = '0;
        case (o)
            OP_ADD:  r = {{(WIDTH-1){1'b0}}, ({1'b0, x} + {1'b0, y})};
            OP_AND:  r = {{WIDTH{1'b0}}, (x & y)};
            OP_XOR:  r = {{WIDTH{1'b0}}, (x ^ y)};
            OP_MUL:  r = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef ALU_ERR_FLAG_EN
        err_d    = 1'b0;
`endif
        // rst_op overrides every state, including an in-flight operation
        if (start && (op == OP_RST)) begin
            result_d = '0;
            cnt_d    = '0;
            busy_d   = 1'b0;
            state_d  = WAIT_LOW;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && (op == OP_ADD || op == OP_AND || op == OP_XOR || op == OP_MUL)) begin
                        a_d     = A;
                        b_d     = B;
                        op_d    = op;
                        busy_d  = 1'b1;
                        cnt_d   = (op == OP_MUL) ? CNT_LOAD : '0;
                        state_d = EXEC;
                    end
`ifdef ALU_ERR_FLAG_EN
                    else if (start && op != OP_NOP) begin
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
`endif
                end
                EXEC: begin
                    if (cnt_q == '0) begin
                        result_d = alu_compute(op_q, a_q, b_q);
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        state_d  = DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    state_d = WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!start) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef ALU_ERR_FLAG_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef ALU_ERR_FLAG_EN
            err_q    <= err_d;
`endif
        end
    end

    // Operand captures are only meaningful once accepted, so they carry no reset
    always_ff @(posedge clk) begin
        a_q  <= a_d;
        b_q  <= b_d;
        op_q <= op_d;
    end

    assign done   = done_q;
    assign busy   = busy_q;
    assign result = result_q;
`ifdef ALU_ERR_FLAG_EN
    assign err    = err_q;
`endif

endmodule

// File: tb/tb_param_alu.sv
// Directed bench for param_alu at WIDTH=8, MUL_CYCLES=3.
module tb_param_alu;

    logic        clk;
    logic        reset_n;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [2:0]  op;
    logic        start;
    logic        done;
    logic [15:0] result;
    logic        busy;
`ifdef ALU_ERR_FLAG_EN
    logic        err;
`endif

    int n_vec  = 0;
    int n_miss = 0;
    int done_seen = 0;

    param_alu #(.WIDTH(8), .MUL_CYCLES(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .A       (A),
        .B       (B),
        .op      (op),
        .start   (start),
        .done    (done),
        .result  (result),
        .busy    (busy)
`ifdef ALU_ERR_FLAG_EN
        ,
        .err     (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_seen++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_out();
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    // lat = edges from the acceptance edge to the done edge
    task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] a,
                          input logic [7:0] b, input int lat, input logic [15:0] exp);
        int cyc;
        int busy_cyc;
        int d0;
        @(negedge clk);
        A = a; B = b; op = o; start = 1'b1;
        d0 = done_seen;
        cyc = 0;
        busy_cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy === 1'b1) busy_cyc++;
            if (cyc == 1) begin
                A = ~a; B = ~b; op = (o == 3'b001) ? 3'b011 : 3'b001;
            end
        end while (done !== 1'b1 && cyc < 40);
        chk({tag, "_latency"}, cyc - 1, lat);
        chk({tag, "_busy_cycles"}, busy_cyc, lat);
        chk({tag, "_result"}, result, exp);
        chk({tag, "_busy_at_done"}, busy, 1'b0);
        @(posedge clk);
        #1;
        chk({tag, "_done_one_cycle"}, done, 1'b0);
        idle_out();
        chk({tag, "_done_count"}, done_seen - d0, 1);
    endtask

    initial begin
        int d0;
        reset_n = 1'b0;
        start = 1'b0;
        A = 8'h00; B = 8'h00; op = 3'b000;
        #2;
        chk("reset_done", done, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_result", result, 16'h0000);
`ifdef ALU_ERR_FLAG_EN
        chk("reset_err", err, 1'b0);
`endif
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        run_op("add_ff_01", 3'b001, 8'hFF, 8'h01, 1, 16'h0100);
        run_op("mul_ff_ff", 3'b100, 8'hFF, 8'hFF, 3, 16'hFE01);
        run_op("and_a5_3c", 3'b010, 8'hA5, 8'h3C, 1, 16'h0024);
        run_op("mul_0d_0b", 3'b100, 8'h0D, 8'h0B, 3, 16'h008F);

        // start held for 10 cycles yields a single done
        @(negedge clk);
        A = 8'hA5; B = 8'h0F; op = 3'b011; start = 1'b1;
        d0 = done_seen;
        repeat (10) @(posedge clk);
        #1;
        chk("xor_held_done_count", done_seen - d0, 1);
        chk("xor_held_result", result, 16'h00AA);
        chk("xor_held_busy", busy, 1'b0);
        idle_out();
        run_op("add_after_held", 3'b001, 8'h01, 8'h02, 1, 16'h0003);

        // asynchronous reset mid-multiply
        @(negedge clk);
        A = 8'h12; B = 8'h34; op = 3'b100; start = 1'b1;
        d0 = done_seen;
        @(posedge clk);
        #1;
        chk("rstn_mul_accepted", busy, 1'b1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rstn_busy_now", busy, 1'b0);
        chk("rstn_result_now", result, 16'h0000);
        chk("rstn_done_now", done, 1'b0);
        op = 3'b001; A = 8'h03; B = 8'h04;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rstn_first_edge_accept", busy, 1'b1);
        @(posedge clk);
        #1;
        chk("rstn_add_done", done, 1'b1);
        chk("rstn_add_result", result, 16'h0007);
        chk("rstn_mul_no_done", done_seen - d0, 0);
        idle_out();

        // rst_op aborts an in-flight multiply
        @(negedge clk);
        A = 8'hFF; B = 8'hFF; op = 3'b100; start = 1'b1;
        d0 = done_seen;
        @(posedge clk);
        #1;
        chk("rstop_mul_busy", busy, 1'b1);
        @(negedge clk);
        op = 3'b111;
        @(posedge clk);
        #1;
        chk("rstop_busy", busy, 1'b0);
        chk("rstop_result", result, 16'h0000);
        repeat (4) @(posedge clk);
        #1;
        chk("rstop_no_done", done_seen - d0, 0);
        idle_out();
        run_op("and_f0_3c", 3'b010, 8'hF0, 8'h3C, 1, 16'h0030);

        // no_op leaves everything untouched
        @(negedge clk);
        A = 8'h11; B = 8'h22; op = 3'b000; start = 1'b1;
        d0 = done_seen;
        repeat (3) @(posedge clk);
        #1;
        chk("nop_busy", busy, 1'b0);
        chk("nop_result", result, 16'h0030);
        chk("nop_no_done", done_seen - d0, 0);
        idle_out();

        // illegal opcode 101
        @(negedge clk);
        A = 8'h01; B = 8'h02; op = 3'b101; start = 1'b1;
        d0 = done_seen;
        @(posedge clk);
        #1;
`ifdef ALU_ERR_FLAG_EN
        chk("ill_done", done, 1'b1);
        chk("ill_err", err, 1'b1);
        chk("ill_busy", busy, 1'b0);
        chk("ill_result", result, 16'h0030);
        @(posedge clk);
        #1;
        chk("ill_done_clear", done, 1'b0);
        chk("ill_err_clear", err, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("ill_done_count", done_seen - d0, 1);
`else
        chk("ill_done", done, 1'b0);
        chk("ill_busy", busy, 1'b0);
        chk("ill_result", result, 16'h0030);
        repeat (3) @(posedge clk);
        #1;
        chk("ill_done_count", done_seen - d0, 0);
`endif
        idle_out();

        // rst_op from IDLE clears the held result
        @(negedge clk);
        op = 3'b111; start = 1'b1;
        @(posedge clk);
        #1;
        chk("rstop_idle_result", result, 16'h0000);
        chk("rstop_idle_done", done, 1'b0);
        idle_out();
        run_op("xor_final", 3'b011, 8'h5A, 8'hFF, 1, 16'h00A5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
